fx2_out_frame_reader: RTL
=========================

# fx2_out_frame_reader

Host-to-device stage for the FX2 slave-FIFO link. It drains 16-bit words from the Cypress OUT endpoint (EP2 by default) over the shared FD bus and delineates them into frames with the structure sync, length, payload and optional checksum. It forwards the payload words through a 2-entry buffered valid/ready stream to the downstream SPI/UART output stages. It shares the FX2 bus with the IN-direction slave-FIFO writer through a request/grant pair owned by the top level.

## Interface
- `EP_ADDR`, default 2'b00: FIFOADR value driven while reading (EP2).
- `SYNC_WORD`, default 16'h55AA: frame start marker.
- `CLK` in 1: the FX2 interface clock (ifclk); the only clock.
- `RST` in 1: reset, synchronous, active-high.
- `FLAG_EMPTY` in 1: FX2 OUT endpoint empty flag, active-high (1 = empty).
- `FD_IN` in 16: FD bus input half (tristate resolved at top).
- `BUS_GNT` in 1: 1 = this block owns SLOE/SLRD/FIFOADR this cycle.
- `BUS_REQ` out 1: request for the FX2 bus.
- `SLOE_N` out 1: FX2 output enable, active-low.
- `SLRD_N` out 1: FX2 read strobe, active-low.
- `FIFOADR` out 2: endpoint select.
- `OUT_DATA` out 16: payload word.
- `OUT_VALID` out 1: OUT_DATA is valid.
- `OUT_LAST` out 1: marks the final payload word of a frame.
- `OUT_READY` in 1: downstream accepts the word.
- `FRAME_OK` out 1: one-cycle pulse when a frame is complete and good.
- `FRAME_ERR` out 1: one-cycle pulse on a bad length or bad checksum.
- `ERR_CNT` out 8: count of FRAME_ERR pulses; saturates at 255.

## Operation
- **States:** IDLE, OE_SETUP, SYNC, LEN, PAYLOAD, CSUM.
- **IDLE:** `BUS_REQ`=!FLAG_EMPTY. Go to OE_SETUP when `BUS_GNT` && !FLAG_EMPTY.
- **OE_SETUP:** `SLOE_N`=0 for one cycle with no read. Next state is the resume state, which is SYNC after reset.
- **Read strobe:** SLRD_N = !(reading state && BUS_GNT && !FLAG_EMPTY && room).
  - Reading states are SYNC, LEN, PAYLOAD and CSUM.
  - room = (buf_cnt<2) || OUT_READY.
  - Outside PAYLOAD, room is forced to 1.
- **Sampling:** `FD_IN` is sampled at the same rising edge at which SLRD_N=0.
- **SYNC:**
  - A word equal to SYNC_WORD moves the state to LEN.
  - Any other word is discarded silently and the state stays in SYNC.
- **LEN:**
  - The length word is {8'h00, N} with N in 1..255. The state moves to PAYLOAD, the remaining count is set to N, and the checksum is cleared.
  - Upper byte ≠0 or N=0 causes FRAME_ERR and a return to SYNC.
- **PAYLOAD:**
  - Each word is pushed into the buffer. The word with remaining==1 is tagged OUT_LAST.
  - The checksum accumulates as sum mod 2^16.
  - After the last word, the state moves to CSUM (or per Configuration).
- **CSUM:**
  - If word == sum: FRAME_OK. Otherwise: FRAME_ERR.
  - Either way, the state returns to SYNC.
  - Payload already forwarded is not retracted. Downstream discards it on FRAME_ERR.
- **Grant loss:** If `BUS_GNT` drops in any reading state, the block sets SLOE_N=1, SLRD_N=1 and returns to IDLE. The parser state is saved as the resume state, and OE_SETUP repeats on re-grant.
- **Empty endpoint:** FLAG_EMPTY=1 mid-frame causes a stall in place. No timeout.
- **Buffer:** 2-entry FIFO. Head word is presented on OUT_*. A pop happens on OUT_VALID && OUT_READY. Push and pop in the same cycle are legal.
- **ERR_CNT** increments on every FRAME_ERR and saturates at 8'hFF.

## Timing
- **Reset values:**
  - SLOE_N=1, SLRD_N=1, FIFOADR=EP_ADDR, BUS_REQ=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0.
  - FRAME_OK=0, FRAME_ERR=0, ERR_CNT=0.
  - State=IDLE, resume state=SYNC, buffer empty.
- **Reset mid-frame:** the frame is dropped and the buffer is flushed. The next read starts with SYNC.
- **Grant to first read:** BUS_GNT seen in IDLE → OE_SETUP next cycle → first SLRD_N=0 the cycle after. That is 2 cycles from grant to first strobe.
- **Throughput:** one word per cycle sustained while FLAG_EMPTY=0, BUS_GNT=1 and OUT_READY=1.
- **Payload latency:** OUT_VALID rises the cycle after the sampling edge, i.e. 1 cycle.
- **Status pulses:** FRAME_OK and FRAME_ERR are registered and asserted the cycle after the deciding word's sampling edge.
- **Buffer full:** buf_cnt==2 && !OUT_READY holds SLRD_N=1. The block never overflows.
- **FIFOADR** is constant at EP_ADDR.

## Configuration
- **`FX2_FRAME_CHECKSUM_EN` defined:** the CSUM state exists as described above.
- **Not defined:**
  - There is no checksum word and no checksum adder.
  - PAYLOAD moves directly to SYNC after the last word.
  - FRAME_OK pulses the cycle after the last word is sampled.
  - FRAME_ERR arises only from a bad length.

## Test plan
- Reset, then frame 55AA, 0003, 0001, 0002, 0003, 0006 with OUT_READY=1 → OUT_DATA 0001/0002/0003 on consecutive cycles, OUT_LAST on 0003, FRAME_OK one pulse, ERR_CNT=0.
- Garbage 1234, FFFF, then a valid 1-word frame 55AA, 0001, BEEF, BEEF → garbage is dropped with no FRAME_ERR, OUT_DATA=BEEF, FRAME_OK.
- Frame with length 0000, then a frame with length 0100 → two FRAME_ERR pulses, ERR_CNT=2, no OUT_VALID.
- 4-word payload with a bad checksum and OUT_READY held 0 → SLRD_N goes high after 2 payload words. Release OUT_READY → remaining words flow, then FRAME_ERR.
- Drop BUS_GNT after the length word, re-grant 5 cycles later → SLOE_N/SLRD_N high during the gap, one OE_SETUP cycle, then the payload resumes and FRAME_OK.
- Built without FX2_FRAME_CHECKSUM_EN: 55AA, 0002, AAAA, BBBB → FRAME_OK the cycle after BBBB is sampled. The next word is parsed as sync.

Source files
------------

// File: rtl/fx2_out_frame_reader.sv
// FX2 slave-FIFO OUT reader: parses sync/length/payload(/checksum) frames and forwards the payload
// through a 2-entry valid/ready buffer. The checksum word is enabled by FX2_FRAME_CHECKSUM_EN.
module fx2_out_frame_reader #(
    parameter logic [1:0]  EP_ADDR   = 2'b00,
    parameter logic [15:0] SYNC_WORD = 16'h55AA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLAG_EMPTY,
    input  logic [15:0] FD_IN,
    input  logic        BUS_GNT,
    output logic        BUS_REQ,
    output logic        SLOE_N,
    output logic        SLRD_N,
    output logic [1:0]  FIFOADR,
    output logic [15:0] OUT_DATA,
    output logic        OUT_VALID,
    output logic        OUT_LAST,
    input  logic        OUT_READY,
    output logic        FRAME_OK,
    output logic        FRAME_ERR,
    output logic [7:0]  ERR_CNT
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] OE_SETUP = 3'd1;
    localparam logic [2:0] SYNC     = 3'd2;
    localparam logic [2:0] LEN      = 3'd3;
    localparam logic [2:0] PAYLOAD  = 3'd4;
`ifdef FX2_FRAME_CHECKSUM_EN
    localparam logic [2:0] CSUM     = 3'd5;
    logic [15:0] sum_q;
`endif

    logic [2:0]  state_q, resume_q;
    logic [7:0]  remaining_q;
    logic [15:0] buf_data_q [2];
    logic        buf_last_q [2];
    logic [1:0]  buf_cnt_q;
    logic        frame_ok_q, frame_err_q;
    logic [7:0]  err_cnt_q;

    logic reading, room, rd, push, pop, len_bad, ok_set, err_set;

    always_comb begin
        reading = (state_q == SYNC) || (state_q == LEN) || (state_q == PAYLOAD);
`ifdef FX2_FRAME_CHECKSUM_EN
        reading = reading || (state_q == CSUM);
`endif
        room    = (state_q != PAYLOAD) || (buf_cnt_q < 2'd2) || OUT_READY;
        rd      = reading && BUS_GNT && !FLAG_EMPTY && room;
        pop     = (buf_cnt_q != 2'd0) && OUT_READY;
        push    = rd && (state_q == PAYLOAD);
        len_bad = (FD_IN[15:8] != 8'h00) || (FD_IN[7:0] == 8'h00);
        ok_set  = 1'b0;
        err_set = 1'b0;
        if (rd) begin
            case (state_q)
                LEN: err_set = len_bad;
`ifdef FX2_FRAME_CHECKSUM_EN
                CSUM: begin
                    ok_set  = (FD_IN == sum_q);
                    err_set = (FD_IN != sum_q);
                end
`else
                PAYLOAD: ok_set = (remaining_q == 8'd1);
`endif
                default: ;
            endcase
        end
    end

    assign BUS_REQ   = (state_q == IDLE) ? !FLAG_EMPTY : 1'b1;
    assign SLOE_N    = !((state_q == OE_SETUP) || (reading && BUS_GNT));
    assign SLRD_N    = !rd;
    assign FIFOADR   = EP_ADDR;
    assign OUT_DATA  = buf_data_q[0];
    assign OUT_VALID = (buf_cnt_q != 2'd0);
    assign OUT_LAST  = buf_last_q[0] && OUT_VALID;
    assign FRAME_OK  = frame_ok_q;
    assign FRAME_ERR = frame_err_q;
    assign ERR_CNT   = err_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            resume_q    <= SYNC;
            remaining_q <= 8'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
`ifdef FX2_FRAME_CHECKSUM_EN
            sum_q       <= 16'd0;
`endif
        end else begin
            frame_ok_q  <= ok_set;
            frame_err_q <= err_set;
            if (err_set && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            case (state_q)
                IDLE:     if (BUS_GNT && !FLAG_EMPTY) state_q <= OE_SETUP;
                OE_SETUP: state_q <= resume_q;
                default: begin
                    if (!reading) begin
                        state_q <= IDLE;
                    end else if (!BUS_GNT) begin
                        // Park the parser; OE_SETUP is replayed on re-grant.
                        resume_q <= state_q;
                        state_q  <= IDLE;
                    end else if (rd) begin
                        case (state_q)
                            SYNC: if (FD_IN == SYNC_WORD) state_q <= LEN;
                            LEN: begin
                                if (len_bad) begin
                                    state_q <= SYNC;
                                end else begin
                                    state_q     <= PAYLOAD;
                                    remaining_q <= FD_IN[7:0];
`ifdef FX2_FRAME_CHECKSUM_EN
                                    sum_q       <= 16'd0;
`endif
                                end
                            end
                            PAYLOAD: begin
                                remaining_q <= remaining_q - 8'd1;
`ifdef FX2_FRAME_CHECKSUM_EN
                                sum_q <= sum_q + FD_IN;
                                if (remaining_q == 8'd1) state_q <= CSUM;
`else
                                if (remaining_q == 8'd1) state_q <= SYNC;
`endif
                            end
                            default: state_q <= SYNC;
                        endcase
                    end
                end
            endcase
        end
    end

    // Shift-register FIFO: entry 0 is always the head presented on OUT_*.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_cnt_q     <= 2'd0;
            buf_data_q[0] <= 16'd0;
            buf_data_q[1] <= 16'd0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    buf_data_q[buf_cnt_q[0]] <= FD_IN;
                    buf_last_q[buf_cnt_q[0]] <= (remaining_q == 8'd1);
                    buf_cnt_q                <= buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    buf_data_q[0] <= buf_data_q[1];
                    buf_last_q[0] <= buf_last_q[1];
                    buf_cnt_q     <= buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf_data_q[0] <= FD_IN;
                        buf_last_q[0] <= (remaining_q == 8'd1);
                    end else begin
                        buf_data_q[0] <= buf_data_q[1];
                        buf_last_q[0] <= buf_last_q[1];
                        buf_data_q[1] <= FD_IN;
                        buf_last_q[1] <= (remaining_q == 8'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
